// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction fields and datapath status in, per-state datapath strobes out.
// slave = control unit side, master = datapath / environment side.
interface mc_control_unit_if #(parameter int ALU_OP_W = 4);
  logic [5:0]          OPCODE;
  logic [5:0]          FUNCT;
  logic                ZERO;
  logic                MEM_READY;
  logic                PC_WRITE;
  logic                IR_WRITE;
  logic                MEM_READ;
  logic                MEM_WRITE;
  logic                I_OR_D;
  logic                REG_DST;
  logic                REG_WRITE;
  logic                EX_TOP;
  logic                ALU_SRC;
  logic [ALU_OP_W-1:0] ALU_OP;
  logic                MEM2REG;
  logic                PC_SRC;
  logic                JUMP;
  logic                INSTR_DONE;
  logic                ERROR;
  logic [2:0]          STATE;

  modport slave (
    input  OPCODE, FUNCT, ZERO, MEM_READY,
    output PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, I_OR_D, REG_DST, REG_WRITE,
           EX_TOP, ALU_SRC, ALU_OP, MEM2REG, PC_SRC, JUMP, INSTR_DONE, ERROR, STATE
  );

  modport master (
    output OPCODE, FUNCT, ZERO, MEM_READY,
    input  PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, I_OR_D, REG_DST, REG_WRITE,
           EX_TOP, ALU_SRC, ALU_OP, MEM2REG, PC_SRC, JUMP, INSTR_DONE, ERROR, STATE
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR) with memory-stall watchdog.
// Optional: define ILLEGAL_TRAP_EN to trap illegal instructions to ERR instead of retiring them as NOPs.
module mc_control_unit #(
  parameter int ALU_OP_W     = 4,
  parameter int MEM_WAIT_MAX = 16,
  parameter int WDOG_W       = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  mc_control_unit_if.slave   bus
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_ERR  = 3'd5
  } state_t;

  typedef struct packed {
    logic                pc_write, ir_write, mem_read, mem_write, i_or_d, reg_dst, reg_write;
    logic                ex_top, alu_src, mem2reg, pc_src, jump, instr_done, error;
    logic [ALU_OP_W-1:0] alu_op;
  } ctl_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010), ALU_SUB = ALU_OP_W'(4'b0110);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000), ALU_OR  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4'b0111), ALU_BEQ = ALU_OP_W'(4'b0101);

  state_t              state, state_nxt;
  logic [WDOG_W-1:0]   wcnt, wcnt_nxt;
  ctl_t                ctl;
  logic [ALU_OP_W-1:0] r_alu;
  logic                funct_ok, is_r, is_lw, is_sw, legal, stall, wdog_trip;

  always_comb begin
    r_alu    = ALU_ADD;
    funct_ok = 1'b1;
    case (bus.FUNCT)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign is_r  = (bus.OPCODE == OP_R);
  assign is_lw = (bus.OPCODE == OP_LW);
  assign is_sw = (bus.OPCODE == OP_SW);
  assign legal = (is_r && funct_ok) || is_lw || is_sw || bus.OPCODE == OP_BEQ ||
                 bus.OPCODE == OP_J || bus.OPCODE == OP_ADDI;

  // Trip on the last allowed stall cycle; a MEM_READY on that cycle still completes normally.
  assign stall     = (state == S_FETCH || state == S_MEM) && !bus.MEM_READY;
  assign wdog_trip = (MEM_WAIT_MAX != 0) && stall && (wcnt == WDOG_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        if (bus.MEM_READY) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_nxt    = S_DECODE;
        end else if (wdog_trip) state_nxt = S_ERR;
      end
      S_DECODE: begin
        if (bus.OPCODE == OP_J) begin
          ctl.jump       = 1'b1;
          ctl.pc_write   = 1'b1;
          ctl.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end else if (legal) state_nxt = S_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_ERR;
`else
          ctl.instr_done = 1'b1;
          state_nxt      = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (bus.OPCODE)
          OP_R: begin
            ctl.alu_op = r_alu;
            state_nxt  = S_WB;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctl.alu_op  = ALU_ADD;
            ctl.alu_src = 1'b1;
            state_nxt   = (bus.OPCODE == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BEQ: begin
            ctl.ex_top     = 1'b1;
            ctl.alu_op     = ALU_BEQ;
            ctl.pc_src     = bus.ZERO;
            ctl.pc_write   = bus.ZERO;
            ctl.instr_done = 1'b1;
            state_nxt      = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_read  = is_lw;
        ctl.mem_write = is_sw;
        if (!is_lw && !is_sw) state_nxt = S_FETCH;
        else if (bus.MEM_READY) begin
          ctl.instr_done = is_sw;
          state_nxt      = is_lw ? S_WB : S_FETCH;
        end else if (wdog_trip) state_nxt = S_ERR;
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        ctl.reg_dst    = is_r;
        ctl.mem2reg    = is_lw;
        state_nxt      = S_FETCH;
      end
      S_ERR:   ctl.error = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Counter clears on any state change or ready; saturates rather than wrapping.
  always_comb begin
    wcnt_nxt = wcnt;
    if (!stall || state_nxt != state) wcnt_nxt = '0;
    else if (wcnt != '1)              wcnt_nxt = wcnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Outputs are forced quiet while reset is held, even before the reset edge lands.
  assign bus.PC_WRITE   = RST_N & ctl.pc_write;
  assign bus.IR_WRITE   = RST_N & ctl.ir_write;
  assign bus.MEM_READ   = RST_N & ctl.mem_read;
  assign bus.MEM_WRITE  = RST_N & ctl.mem_write;
  assign bus.I_OR_D     = RST_N & ctl.i_or_d;
  assign bus.REG_DST    = RST_N & ctl.reg_dst;
  assign bus.REG_WRITE  = RST_N & ctl.reg_write;
  assign bus.EX_TOP     = RST_N & ctl.ex_top;
  assign bus.ALU_SRC    = RST_N & ctl.alu_src;
  assign bus.ALU_OP     = RST_N ? ctl.alu_op : '0;
  assign bus.MEM2REG    = RST_N & ctl.mem2reg;
  assign bus.PC_SRC     = RST_N & ctl.pc_src;
  assign bus.JUMP       = RST_N & ctl.jump;
  assign bus.INSTR_DONE = RST_N & ctl.instr_done;
  assign bus.ERROR      = RST_N & ctl.error;
  assign bus.STATE      = RST_N ? state : 3'd0;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle check of STATE, ALU_OP and every strobe.
module tb_mc_control_unit;
  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;

  mc_control_unit_if #(.ALU_OP_W(4)) bus ();
  mc_control_unit #(.ALU_OP_W(4), .MEM_WAIT_MAX(4), .WDOG_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [13:0] PCW = 14'h2000, IRW = 14'h1000, MR = 14'h0800, MW = 14'h0400;
  localparam logic [13:0] IOD = 14'h0200, RD = 14'h0100, RW = 14'h0080, EXT = 14'h0040;
  localparam logic [13:0] AS = 14'h0020, M2R = 14'h0010, PCS = 14'h0008, JMP = 14'h0004;
  localparam logic [13:0] DONE = 14'h0002, ERRF = 14'h0001, NONE = 14'h0000;
  localparam logic [13:0] FET = PCW | IRW | MR;

  logic [13:0] ctl;
  assign ctl = {bus.PC_WRITE, bus.IR_WRITE, bus.MEM_READ, bus.MEM_WRITE, bus.I_OR_D,
                bus.REG_DST, bus.REG_WRITE, bus.EX_TOP, bus.ALU_SRC, bus.MEM2REG,
                bus.PC_SRC, bus.JUMP, bus.INSTR_DONE, bus.ERROR};

  // Apply inputs, check the combinational outputs of the current state, then advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic zr,
                     input logic [2:0] es, input logic [3:0] ea, input logic [13:0] ec);
    logic [20:0] obs, exp;
    bus.MEM_READY = rdy;
    bus.ZERO      = zr;
    #1;
    obs = {bus.STATE, bus.ALU_OP, ctl};
    exp = {es, ea, ec};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed state=%0d alu=%b ctl=%b expected state=%0d alu=%b ctl=%b",
             tag, obs[20:18], obs[17:14], obs[13:0], exp[20:18], exp[17:14], exp[13:0]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    bus.OPCODE = op;
    bus.FUNCT  = fn;
  endtask

  initial begin
    RST_N = 1'b0;
    bus.MEM_READY = 1'b0; bus.ZERO = 1'b0;
    instr(6'b000000, 6'b000000);
    @(posedge CLK); #1;
    cyc("reset_quiet", 1'b1, 1'b0, 3'd0, 4'b0000, NONE);
    RST_N = 1'b1;

    // add: 4 cycles
    instr(6'b000000, 6'b100000);
    cyc("add_fetch",  1, 0, 3'd0, 4'b0000, FET);
    cyc("add_decode", 1, 0, 3'd1, 4'b0000, NONE);
    cyc("add_exec",   1, 0, 3'd2, 4'b0010, NONE);
    cyc("add_wb",     1, 0, 3'd4, 4'b0000, RW | RD | DONE);

    // sub: checks funct decode
    instr(6'b000000, 6'b100010);
    cyc("sub_fetch",  1, 0, 3'd0, 4'b0000, FET);
    cyc("sub_decode", 1, 0, 3'd1, 4'b0000, NONE);
    cyc("sub_exec",   1, 0, 3'd2, 4'b0110, NONE);
    cyc("sub_wb",     1, 0, 3'd4, 4'b0000, RW | RD | DONE);

    // lw with 3 wait states in MEM: 8 cycles
    instr(6'b100011, 6'b000000);
    cyc("lw_fetch",   1, 0, 3'd0, 4'b0000, FET);
    cyc("lw_decode",  1, 0, 3'd1, 4'b0000, NONE);
    cyc("lw_exec",    1, 0, 3'd2, 4'b0010, AS);
    cyc("lw_mem_w1",  0, 0, 3'd3, 4'b0000, MR | IOD);
    cyc("lw_mem_w2",  0, 0, 3'd3, 4'b0000, MR | IOD);
    cyc("lw_mem_w3",  0, 0, 3'd3, 4'b0000, MR | IOD);
    cyc("lw_mem_rdy", 1, 0, 3'd3, 4'b0000, MR | IOD);
    cyc("lw_wb",      1, 0, 3'd4, 4'b0000, RW | M2R | DONE);

    // sw: retires from MEM
    instr(6'b101011, 6'b000000);
    cyc("sw_fetch",   1, 0, 3'd0, 4'b0000, FET);
    cyc("sw_decode",  1, 0, 3'd1, 4'b0000, NONE);
    cyc("sw_exec",    1, 0, 3'd2, 4'b0010, AS);
    cyc("sw_mem",     1, 0, 3'd3, 4'b0000, MW | IOD | DONE);

    // addi: rt destination
    instr(6'b001000, 6'b000000);
    cyc("addi_fetch", 1, 0, 3'd0, 4'b0000, FET);
    cyc("addi_dec",   1, 0, 3'd1, 4'b0000, NONE);
    cyc("addi_exec",  1, 0, 3'd2, 4'b0010, AS);
    cyc("addi_wb",    1, 0, 3'd4, 4'b0000, RW | DONE);

    // beq taken / not taken
    instr(6'b000100, 6'b000000);
    cyc("beqt_fetch", 1, 1, 3'd0, 4'b0000, FET);
    cyc("beqt_dec",   1, 1, 3'd1, 4'b0000, NONE);
    cyc("beqt_exec",  1, 1, 3'd2, 4'b0101, EXT | PCS | PCW | DONE);
    cyc("beqn_fetch", 1, 0, 3'd0, 4'b0000, FET);
    cyc("beqn_dec",   1, 0, 3'd1, 4'b0000, NONE);
    cyc("beqn_exec",  1, 0, 3'd2, 4'b0101, EXT | DONE);

    // j: 2 cycles
    instr(6'b000010, 6'b000000);
    cyc("j_fetch",    1, 0, 3'd0, 4'b0000, FET);
    cyc("j_decode",   1, 0, 3'd1, 4'b0000, JMP | PCW | DONE);

    // ready on the 4th stall cycle wins over the watchdog
    cyc("wd_edge_s1", 0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_edge_s2", 0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_edge_s3", 0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_edge_rdy", 1, 0, 3'd0, 4'b0000, FET);
    cyc("wd_edge_dec", 1, 0, 3'd1, 4'b0000, JMP | PCW | DONE);

    // stuck fetch: ERR after 4 stall cycles, sticky
    cyc("wd_s1",      0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_s2",      0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_s3",      0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_s4",      0, 0, 3'd0, 4'b0000, MR);
    cyc("wd_err",     1, 0, 3'd5, 4'b0000, ERRF);
    cyc("wd_err_hold", 1, 0, 3'd5, 4'b0000, ERRF);
    RST_N = 1'b0;
    cyc("wd_reset",   0, 0, 3'd0, 4'b0000, NONE);
    RST_N = 1'b1;
    cyc("wd_after_rst", 0, 0, 3'd0, 4'b0000, MR);

    // illegal opcode
    instr(6'b111111, 6'b000000);
    cyc("ill_fetch",  1, 0, 3'd0, 4'b0000, FET);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_decode", 1, 0, 3'd1, 4'b0000, NONE);
    cyc("ill_err",    1, 0, 3'd5, 4'b0000, ERRF);
`else
    cyc("ill_decode", 1, 0, 3'd1, 4'b0000, DONE);
    cyc("ill_refetch", 1, 0, 3'd0, 4'b0000, FET);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and emits per-state datapath controls, so that one ALU and one unified memory can be shared. It adds a memory wait-state handshake, a memory-stall watchdog, and a retire pulse. It sits between the instruction register (OPCODE/FUNCT fields) and the datapath muxes, register file, PC and memory.

Parameters:
ALU_OP_W, 4, width of ALU_OP; codes are add=0010, sub=0110, and=0000, or=0001, slt=0111, beq-compare=0101, zero-extended if wider
MEM_WAIT_MAX, 16, max consecutive stall cycles in FETCH or MEM before ERR; 0 disables the watchdog
WDOG_W, 5, width of stall counter; must satisfy 2^WDOG_W > MEM_WAIT_MAX

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  synchronous active-low reset
OPCODE  in  6  IR[31:26], valid from DECODE onward
FUNCT  in  6  IR[5:0]
ZERO  in  1  ALU zero flag
MEM_READY  in  1  memory completes the current access this cycle
PC_WRITE  out  1  load PC
IR_WRITE  out  1  load instruction register
MEM_READ  out  1  memory read request
MEM_WRITE  out  1  memory write request
I_OR_D  out  1  0 = memory address from PC, 1 = from ALU result
REG_DST  out  1  1 = rd destination, 0 = rt
REG_WRITE  out  1  register file write enable
EX_TOP  out  1  branch-compare select
ALU_SRC  out  1  1 = immediate operand
ALU_OP  out  ALU_OP_W  ALU operation
MEM2REG  out  1  1 = writeback from memory data
PC_SRC  out  1  1 = branch target
JUMP  out  1  1 = jump target
INSTR_DONE  out  1  one-cycle pulse on instruction retire
ERROR  out  1  sticky fault flag
STATE  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. Values 6 and 7 go to FETCH.
- Reset (RST_N low at an edge): state=FETCH, stall counter=0, ERROR=0. Reset mid-instruction aborts it with no retire pulse.
- Outputs are combinational from state and OPCODE/FUNCT. Every output not listed for a state is 0. During RST_N low all outputs are 0 except STATE=0.
- FETCH:
  - MEM_READ=1, I_OR_D=0.
  - When MEM_READY=1: IR_WRITE=1, PC_WRITE=1 (PC+4), next state DECODE. Otherwise hold.
- DECODE: no strobes.
  - j: JUMP=1, PC_WRITE=1, INSTR_DONE=1, next state FETCH.
  - Legal non-jump: next state EXEC.
  - Illegal opcode, or R-type with unknown funct: behaviour per the optional feature.
- EXEC:
  - R-type: ALU_OP per funct, ALU_SRC=0, next state WB.
  - addi, lw, sw: ALU_OP=add, ALU_SRC=1. addi goes to WB; lw and sw go to MEM.
  - beq: EX_TOP=1, ALU_OP=0101, PC_SRC=ZERO, PC_WRITE=ZERO, INSTR_DONE=1, next state FETCH.
- MEM:
  - I_OR_D=1. lw: MEM_READ=1. sw: MEM_WRITE=1.
  - Request is held until MEM_READY=1. Then lw goes to WB; sw pulses INSTR_DONE and goes to FETCH.
- WB:
  - REG_WRITE=1 and INSTR_DONE=1.
  - R-type: REG_DST=1, MEM2REG=0. addi: REG_DST=0, MEM2REG=0. lw: REG_DST=0, MEM2REG=1.
  - Next state FETCH.
- Cycle counts with zero wait states: R-type/addi 4, lw 5, sw 4, beq 3, j 2. Each stall cycle adds 1.
- Watchdog:
  - The counter increments each cycle in FETCH or MEM with MEM_READY=0. It clears on MEM_READY=1 or on any state change.
  - If MEM_WAIT_MAX≠0 and counter==MEM_WAIT_MAX-1 with MEM_READY still 0, next state is ERR. MEM_READY=1 on that same cycle wins: the access completes normally.
  - The counter saturates and never wraps.
- ERR: all strobes 0, ERROR=1; the state is held until reset.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct in DECODE moves the FSM to ERR and sets ERROR=1.
- Undefined: an illegal instruction is a NOP. DECODE pulses INSTR_DONE and returns to FETCH, with no other strobes and ERROR staying 0.

Test Plan:
- add (OPCODE=0, FUNCT=100000), MEM_READY always 1 -> STATE 0,1,2,4,0. ALU_OP=0010 in EXEC. REG_WRITE=1 and REG_DST=1 in WB. Exactly one INSTR_DONE in WB.
- lw (100011) with MEM_READY low for 3 cycles in MEM -> MEM_READ=1 and I_OR_D=1 held for 4 cycles. WB has MEM2REG=1. Total 8 cycles.
- beq (000100) once with ZERO=1, once with ZERO=0 -> PC_WRITE=PC_SRC=1 in EXEC for the first, 0 for the second. Both take 3 cycles with INSTR_DONE in EXEC.
- MEM_WAIT_MAX=4, MEM_READY stuck 0 in FETCH -> ERR entered after 4 FETCH cycles, ERROR=1 held. RST_N low for one edge -> STATE=0, ERROR=0.
- MEM_READY rises on exactly the 4th stall cycle -> no ERR, DECODE follows.
- OPCODE=111111 -> with ILLEGAL_TRAP_EN: ERR, ERROR=1. Without: INSTR_DONE in DECODE, back to FETCH, ERROR=0.
